// File: rtl/gesture_pkg.sv
// Shared definitions for the 4-bit motor command interface {speed[3:2], steer[1:0]}.
package gesture_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0]  END_BYTE_DEF  = 8'h5A;
  localparam int unsigned CMD_W         = 4;

  typedef struct packed {
    logic [1:0] speed;
    logic [1:0] steer;
  } cmd_t;

  localparam cmd_t CMD_STOP = cmd_t'(4'b0000);

  typedef enum logic [1:0] {
    HUNT,
    GOT_SYNC,
    GOT_CMD
  } state_e;

  // A command byte carries its payload in [3:0] and the complement in [7:4].
  function automatic logic cmd_byte_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Link watchdog: armed by a kick, drops link_ok and pulses timeout_o after TIMEOUT_CYC idle cycles.
module link_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic kick_i,
  output logic link_ok_o,
  output logic timeout_o,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             link_q, link_d;
  logic             to_q, to_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      link_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      link_q <= link_d;
      to_q   <= to_d;
    end
  end

  // A kick on the expiry cycle wins over the expiry.
  always_comb begin
    cnt_d    = cnt_q;
    link_d   = link_q;
    to_d     = 1'b0;
    expire_c = link_q && !kick_i && (cnt_q == CNT_LAST);
    if (kick_i) begin
      cnt_d  = '0;
      link_d = 1'b1;
    end else if (expire_c) begin
      cnt_d  = '0;
      link_d = 1'b0;
      to_d   = 1'b1;
    end else if (link_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign link_ok_o = link_q;
  assign timeout_o = to_q;

endmodule

// File: rtl/gesture_cmd_receiver.sv
// Parses SYNC/CMD/END byte frames into a registered motor command with a link failsafe.
// Optional error statistics outputs (bad_cnt, to_cnt) are built when ERR_STATS_EN is defined.
module gesture_cmd_receiver
  import gesture_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0]  END_BYTE    = END_BYTE_DEF,
  parameter int unsigned GAP_CYC     = 125_000,
  parameter int unsigned TIMEOUT_CYC = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] cmd_nibble,
  output logic       cmd_update,
  output logic       link_ok,
  output logic       bad_frame,
  output logic       timeout
`ifdef ERR_STATS_EN
  ,
  output logic [7:0] bad_cnt,
  output logic [7:0] to_cnt
`endif
);

  localparam int unsigned      GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_e           state_q, state_d;
  cmd_t             payload_q, payload_d;
  cmd_t             cmd_q, cmd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             upd_q, upd_d;
  logic             bad_q, bad_d;
  logic             kick_c;
  logic             wd_expire_c;
  state_e           resync_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      payload_q <= CMD_STOP;
      cmd_q     <= CMD_STOP;
      gap_q     <= '0;
      upd_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      cmd_q     <= cmd_d;
      gap_q     <= gap_d;
      upd_q     <= upd_d;
      bad_q     <= bad_d;
    end
  end

  assign kick_c   = rx_valid && (state_q == GOT_CMD) && (rx_data == END_BYTE);
  assign resync_c = (rx_data == SYNC_BYTE) ? GOT_SYNC : HUNT;

  // A SYNC byte in the CMD slot is treated as a fresh frame start, never as a payload.
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    cmd_d     = cmd_q;
    gap_d     = gap_q;
    upd_d     = 1'b0;
    bad_d     = 1'b0;
    if (rx_valid) begin
      gap_d = '0;
      case (state_q)
        HUNT: begin
          if (rx_data == SYNC_BYTE) state_d = GOT_SYNC;
        end
        GOT_SYNC: begin
          if (cmd_byte_ok(rx_data) && (rx_data != SYNC_BYTE)) begin
            payload_d = cmd_t'(rx_data[CMD_W-1:0]);
            state_d   = GOT_CMD;
          end else begin
            bad_d   = 1'b1;
            state_d = resync_c;
          end
        end
        GOT_CMD: begin
          if (rx_data == END_BYTE) begin
            cmd_d   = payload_q;
            upd_d   = 1'b1;
            state_d = HUNT;
          end else begin
            bad_d   = 1'b1;
            state_d = resync_c;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT) begin
      if (gap_q == GAP_LAST) begin
        state_d = HUNT;
        bad_d   = 1'b1;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end else begin
      gap_d = '0;
    end
    if (wd_expire_c) cmd_d = CMD_STOP;
  end

  link_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_link_watchdog (
    .clk       (clk),
    .reset     (reset),
    .kick_i    (kick_c),
    .link_ok_o (link_ok),
    .timeout_o (timeout),
    .expire_c  (wd_expire_c)
  );

  assign cmd_nibble = cmd_q;
  assign cmd_update = upd_q;
  assign bad_frame  = bad_q;

`ifdef ERR_STATS_EN
  logic [7:0] bad_cnt_q;
  logic [7:0] to_cnt_q;

  // Saturating error counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      if (bad_q && (bad_cnt_q != 8'hFF)) bad_cnt_q <= bad_cnt_q + 8'd1;
      if (timeout && (to_cnt_q != 8'hFF)) to_cnt_q <= to_cnt_q + 8'd1;
    end
  end

  assign bad_cnt = bad_cnt_q;
  assign to_cnt  = to_cnt_q;
`endif

endmodule

// File: tb/tb_gesture_cmd_receiver.sv
// Directed self-checking bench for gesture_cmd_receiver (GAP_CYC=16, TIMEOUT_CYC=100).
module tb_gesture_cmd_receiver;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] cmd_nibble;
  logic       cmd_update;
  logic       link_ok;
  logic       bad_frame;
  logic       timeout;
`ifdef ERR_STATS_EN
  logic [7:0] bad_cnt;
  logic [7:0] to_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  gesture_cmd_receiver #(
    .GAP_CYC     (16),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_nibble (cmd_nibble),
    .cmd_update (cmd_update),
    .link_ok    (link_ok),
    .bad_frame  (bad_frame),
    .timeout    (timeout)
`ifdef ERR_STATS_EN
    ,
    .bad_cnt    (bad_cnt),
    .to_cnt     (to_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte is sampled at the next edge; returns 1 time unit after that edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(2);
    check_eq("rst_cmd",     8'(cmd_nibble), 8'h0);
    check_eq("rst_link",    8'(link_ok),    8'h0);
    check_eq("rst_upd",     8'(cmd_update), 8'h0);
    check_eq("rst_bad",     8'(bad_frame),  8'h0);
    check_eq("rst_timeout", 8'(timeout),    8'h0);
    reset = 1'b0;
    idle(1);

    // Good frame, payload 1
    send(8'h33);
    check_eq("hunt_garbage_bad", 8'(bad_frame), 8'h0);
    send(8'hA5);
    send(8'hE1);
    check_eq("f1_bad_cmd", 8'(bad_frame), 8'h0);
    send(8'h5A);
    check_eq("f1_cmd",  8'(cmd_nibble), 8'h1);
    check_eq("f1_upd",  8'(cmd_update), 8'h1);
    check_eq("f1_link", 8'(link_ok),    8'h1);
    check_eq("f1_bad",  8'(bad_frame),  8'h0);
    idle(1);
    check_eq("f1_upd_pulse", 8'(cmd_update), 8'h0);

    // Invalid CMD, trailing END ignored
    send(8'hA5);
    send(8'hE2);
    check_eq("f2_bad", 8'(bad_frame), 8'h1);
    send(8'h5A);
    check_eq("f2_bad_pulse", 8'(bad_frame),  8'h0);
    check_eq("f2_upd",       8'(cmd_update), 8'h0);
    check_eq("f2_cmd",       8'(cmd_nibble), 8'h1);

    // Double SYNC resyncs
    send(8'hA5);
    send(8'hA5);
    check_eq("f3_resync_bad", 8'(bad_frame), 8'h1);
    send(8'h96);
    check_eq("f3_cmd_bad", 8'(bad_frame), 8'h0);
    send(8'h5A);
    check_eq("f3_cmd", 8'(cmd_nibble), 8'h6);
    check_eq("f3_upd", 8'(cmd_update), 8'h1);

    // Byte arriving on the gap expiry cycle is processed
    send(8'hA5);
    idle(15);
    check_eq("gap_edge_pre", 8'(bad_frame), 8'h0);
    send(8'h96);
    check_eq("gap_edge_bad", 8'(bad_frame), 8'h0);
    send(8'h5A);
    check_eq("gap_edge_upd", 8'(cmd_update), 8'h1);
    check_eq("gap_edge_cmd", 8'(cmd_nibble), 8'h6);

    // Gap expiry drops the frame
    send(8'hA5);
    idle(15);
    check_eq("gap_pre", 8'(bad_frame), 8'h0);
    idle(1);
    check_eq("gap_bad", 8'(bad_frame), 8'h1);
    idle(1);
    check_eq("gap_bad_pulse", 8'(bad_frame), 8'h0);
    send(8'h96);
    send(8'h5A);
    check_eq("gap_no_upd", 8'(cmd_update), 8'h0);
    check_eq("gap_cmd",    8'(cmd_nibble), 8'h6);

    // Wrong END byte
    send(8'hA5);
    send(8'hE1);
    send(8'h77);
    check_eq("end_bad",  8'(bad_frame),  8'h1);
    check_eq("end_cmd",  8'(cmd_nibble), 8'h6);

    // Watchdog expiry after commit of 9
    send(8'hA5);
    send(8'h69);
    send(8'h5A);
    check_eq("wd_cmd9", 8'(cmd_nibble), 8'h9);
    idle(99);
    check_eq("wd_pre_to",   8'(timeout),    8'h0);
    check_eq("wd_pre_link", 8'(link_ok),    8'h1);
    check_eq("wd_pre_cmd",  8'(cmd_nibble), 8'h9);
    idle(1);
    check_eq("wd_to",   8'(timeout),    8'h1);
    check_eq("wd_cmd0", 8'(cmd_nibble), 8'h0);
    check_eq("wd_link", 8'(link_ok),    8'h0);
    idle(1);
    check_eq("wd_to_pulse", 8'(timeout), 8'h0);
    idle(150);
    check_eq("wd_disarmed", 8'(timeout), 8'h0);

    // Commit landing exactly on the expiry cycle
    send(8'hA5);
    send(8'hC3);
    send(8'h5A);
    check_eq("co_cmd3", 8'(cmd_nibble), 8'h3);
    idle(97);
    send(8'hA5);
    send(8'h3C);
    check_eq("co_link_pre", 8'(link_ok), 8'h1);
    send(8'h5A);
    check_eq("co_to",   8'(timeout),    8'h0);
    check_eq("co_cmd",  8'(cmd_nibble), 8'hC);
    check_eq("co_upd",  8'(cmd_update), 8'h1);
    check_eq("co_link", 8'(link_ok),    8'h1);
    idle(1);
    check_eq("co_to_after", 8'(timeout), 8'h0);

    // Same payload still pulses update
    send(8'hA5);
    send(8'h3C);
    send(8'h5A);
    check_eq("same_upd", 8'(cmd_update), 8'h1);
    check_eq("same_cmd", 8'(cmd_nibble), 8'hC);

    // Reset mid-frame discards the partial frame
    send(8'hA5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_eq("mrst_cmd",  8'(cmd_nibble), 8'h0);
    check_eq("mrst_link", 8'(link_ok),    8'h0);
    check_eq("mrst_upd",  8'(cmd_update), 8'h0);
    check_eq("mrst_bad",  8'(bad_frame),  8'h0);
    check_eq("mrst_to",   8'(timeout),    8'h0);
    send(8'hE1);
    send(8'h5A);
    check_eq("mrst_no_upd",  8'(cmd_update), 8'h0);
    check_eq("mrst_cmd_aft", 8'(cmd_nibble), 8'h0);
    check_eq("mrst_link_aft", 8'(link_ok),   8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
